// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that turns a framed byte stream into instruction-memory word writes
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   restart         1-cycle pulse: abort any load and re-arm for a new frame
//   in_valid/in_ready/in_data   byte stream handshake (in_ready is registered)
//   mem_we/mem_addr/mem_wdata   instruction-memory write port, one strobe per word
//   cpu_hold        1 keeps the core's fetch/PC in reset until the image is loaded
//   load_done       image loaded (and verified when checksumming), sticky
//   load_err        checksum mismatch, sticky (tied 0 without checksumming)
// Frame: LEN (16-bit word count, high byte first), LEN words high byte first,
// then one XOR checksum byte over the word bytes when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_W     = 20,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

  typedef enum logic [2:0] {
    LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE
`ifdef IMEM_LOADER_CHECKSUM_EN
    , CHK, ERROR
`endif
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       cnt;
  logic [15:0]       len;
  logic [7:0]        word_hi;
  logic              acc;

  assign acc = in_valid & in_ready;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] chk;
`else
  assign load_err = 1'b0;
`endif

  // in_ready is registered, so every transition also sets the in_ready value
  // that belongs to the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LEN_HI;
      addr      <= START;
      cnt       <= '0;
      len       <= '0;
      word_hi   <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= START;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk       <= '0;
      load_err  <= 1'b0;
`endif
    end else if (restart) begin
      // a byte accepted in this cycle is dropped; a write already strobed has completed
      state     <= LEN_HI;
      addr      <= START;
      cnt       <= '0;
      in_ready  <= 1'b1;
      mem_we    <= 1'b0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk       <= '0;
      load_err  <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        LEN_HI: begin
          in_ready <= 1'b1;
          if (acc) begin
            len[15:8] <= in_data;
            state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (acc) begin
            len[7:0] <= in_data;
            if ({len[15:8], in_data} != 16'd0) begin
              state <= DATA_HI;
            end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state     <= DONE;
              in_ready  <= 1'b0;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
`endif
            end
          end
        end
        DATA_HI: begin
          if (acc) begin
            word_hi <= in_data;
            state   <= DATA_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk     <= chk ^ in_data;
`endif
          end
        end
        DATA_LO: begin
          if (acc) begin
            state     <= WRITE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= {word_hi, in_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk       <= chk ^ in_data;
`endif
          end
        end
        WRITE: begin
          addr <= addr + 1'b1;
          cnt  <= cnt + 16'd1;
          if (cnt + 16'd1 != len) begin
            state    <= DATA_HI;
            in_ready <= 1'b1;
          end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state    <= CHK;
            in_ready <= 1'b1;
`else
            state     <= DONE;
            in_ready  <= 1'b0;
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (acc) begin
            in_ready <= 1'b0;
            if (in_data == chk) begin
              state     <= DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state    <= ERROR;
              load_err <= 1'b1;
            end
          end
        end
`endif
        default: in_ready <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader (default and 4-bit-address instances)
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        restart = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        in_ready, mem_we, cpu_hold, load_done, load_err;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        in_ready2, mem_we2, cpu_hold2, load_done2, load_err2;
  logic [3:0]  mem_addr2;
  logic [15:0] mem_wdata2;

  int total = 0;
  int bad = 0;

  logic [15:0] words [0:7];
  logic [19:0] wa [$];
  logic [15:0] wd [$];
  logic [3:0]  wa2 [$];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  imem_loader #(.ADDR_W(4), .START_ADDR(14)) dut2 (
    .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .cpu_hold(cpu_hold2), .load_done(load_done2), .load_err(load_err2)
  );

  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (mem_we2) wa2.push_back(mem_addr2);
  end

  task clear_log;
    wa.delete();
    wd.delete();
    wa2.delete();
  endtask

  task send_byte(input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_byte_timeout in_ready=%b want=1 byte=%h", in_ready, b);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task send_frame(input int n);
    send_byte(8'(n >> 8));
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      send_byte(words[i][15:8]);
      send_byte(words[i][7:0]);
    end
  endtask

  task pulse_restart;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task test_reset;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    total++; if (mem_addr !== 20'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    total++; if (mem_addr2 !== 4'd14) begin bad++; $display("FAIL rst_mem_addr2 got=%0d exp=14", mem_addr2); end
    total++; if (mem_wdata !== 16'h0) begin bad++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL rst_cpu_hold got=%b exp=1", cpu_hold); end
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL rst_load_done got=%b exp=0", load_done); end
    total++; if (load_err !== 1'b0) begin bad++; $display("FAIL rst_load_err got=%b exp=0", load_err); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
  endtask

  task test_basic;
    clear_log();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL basic_w0_we got=%b exp=1", mem_we); end
    total++; if (mem_addr !== 20'h0) begin bad++; $display("FAIL basic_w0_addr got=%h exp=0", mem_addr); end
    total++; if (mem_wdata !== 16'h1234) begin bad++; $display("FAIL basic_w0_data got=%h exp=1234", mem_wdata); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_write_ready got=%b exp=0", in_ready); end
    send_byte(8'hAB); send_byte(8'hCD);
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL basic_w1_we got=%b exp=1", mem_we); end
    total++; if (mem_addr !== 20'h1) begin bad++; $display("FAIL basic_w1_addr got=%h exp=1", mem_addr); end
    total++; if (mem_wdata !== 16'hABCD) begin bad++; $display("FAIL basic_w1_data got=%h exp=abcd", mem_wdata); end
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL basic_early_done got=%b exp=0", load_done); end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h40);
`else
    @(negedge clk);
`endif
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b exp=1", load_done); end
    total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL basic_hold got=%b exp=0", cpu_hold); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_done_ready got=%b exp=0", in_ready); end
    total++; if (mem_we !== 1'b0 || mem_addr !== 20'h1 || mem_wdata !== 16'hABCD) begin
      bad++; $display("FAIL basic_hold_outputs got=%b/%h/%h exp=0/1/abcd", mem_we, mem_addr, mem_wdata);
    end
    in_valid = 1'b1; in_data = 8'hFF;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    total++; if (load_done !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL basic_ignore got=%b/%b exp=1/0", load_done, in_ready); end
    total++; if (wa.size() !== 2) begin bad++; $display("FAIL basic_nwrites got=%0d exp=2", wa.size()); end
    else begin
      total++; if (wa[0] !== 20'h0 || wd[0] !== 16'h1234) begin bad++; $display("FAIL basic_log0 got=%h/%h exp=0/1234", wa[0], wd[0]); end
      total++; if (wa[1] !== 20'h1 || wd[1] !== 16'hABCD) begin bad++; $display("FAIL basic_log1 got=%h/%h exp=1/abcd", wa[1], wd[1]); end
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task test_bad_chk;
    pulse_restart();
    total++; if (load_done !== 1'b0 || cpu_hold !== 1'b1) begin bad++; $display("FAIL badchk_restart got=%b/%b exp=0/1", load_done, cpu_hold); end
    clear_log();
    words[0] = 16'h1234; words[1] = 16'hABCD;
    send_frame(2);
    send_byte(8'h41);
    total++; if (load_err !== 1'b1) begin bad++; $display("FAIL badchk_err got=%b exp=1", load_err); end
    total++; if (cpu_hold !== 1'b1 || load_done !== 1'b0) begin bad++; $display("FAIL badchk_hold got=%b/%b exp=1/0", cpu_hold, load_done); end
    total++; if (wa.size() !== 2) begin bad++; $display("FAIL badchk_nwrites got=%0d exp=2", wa.size()); end
    pulse_restart();
    total++; if (load_err !== 1'b0) begin bad++; $display("FAIL badchk_clear got=%b exp=0", load_err); end
    send_frame(2);
    send_byte(8'h40);
    total++; if (load_done !== 1'b1 || load_err !== 1'b0) begin bad++; $display("FAIL badchk_reload got=%b/%b exp=1/0", load_done, load_err); end
  endtask
`endif

  task test_empty;
    pulse_restart();
    clear_log();
    send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL empty_early got=%b exp=0", load_done); end
    send_byte(8'h00);
`endif
    total++; if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin bad++; $display("FAIL empty_done got=%b/%b exp=1/0", load_done, cpu_hold); end
    repeat (2) @(negedge clk);
    total++; if (wa.size() !== 0) begin bad++; $display("FAIL empty_nwrites got=%0d exp=0", wa.size()); end
  endtask

  task test_restart;
    pulse_restart();
    in_valid = 1'b1; in_data = 8'hFF; restart = 1'b1;
    @(negedge clk);
    restart = 1'b0; in_valid = 1'b0;
    clear_log();
    words[0] = 16'h5566;
    send_frame(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h33);
`endif
    repeat (2) @(negedge clk);
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL restart_drop_done got=%b exp=1", load_done); end
    total++; if (wa.size() !== 1) begin bad++; $display("FAIL restart_drop_nwrites got=%0d exp=1", wa.size()); end
    else begin
      total++; if (wa[0] !== 20'h0 || wd[0] !== 16'h5566) begin bad++; $display("FAIL restart_drop_log got=%h/%h exp=0/5566", wa[0], wd[0]); end
    end
    pulse_restart();
    clear_log();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    total++; if (mem_we !== 1'b0 || in_ready !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin
      bad++; $display("FAIL restart_write_state got=%b/%b/%b/%b exp=0/1/1/0", mem_we, in_ready, cpu_hold, load_done);
    end
    words[0] = 16'h7788;
    send_frame(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hFF);
`endif
    repeat (2) @(negedge clk);
    total++; if (wa.size() !== 2) begin bad++; $display("FAIL restart_write_nwrites got=%0d exp=2", wa.size()); end
    else begin
      total++; if (wd[0] !== 16'h1122) begin bad++; $display("FAIL restart_write_kept got=%h exp=1122", wd[0]); end
      total++; if (wa[1] !== 20'h0 || wd[1] !== 16'h7788) begin bad++; $display("FAIL restart_write_new got=%h/%h exp=0/7788", wa[1], wd[1]); end
    end
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL restart_write_done got=%b exp=1", load_done); end
  endtask

  task test_back_to_back;
    logic [7:0] b [0:15];
    logic [7:0] c;
    int nb, idx, cyc, wr_seen;
    logic acc;
    pulse_restart();
    clear_log();
    words[0] = 16'h0F1E; words[1] = 16'h2D3C; words[2] = 16'h4B5A; words[3] = 16'h6978; words[4] = 16'h8796;
    b[0] = 8'h00; b[1] = 8'h05;
    for (int i = 0; i < 5; i++) begin
      b[2 + 2 * i] = words[i][15:8];
      b[3 + 2 * i] = words[i][7:0];
    end
    nb = 12;
`ifdef IMEM_LOADER_CHECKSUM_EN
    c = 8'h00;
    for (int j = 2; j < 12; j++) c = c ^ b[j];
    b[12] = c;
    nb = 13;
`else
    c = 8'h00;
`endif
    idx = 0; cyc = 0; wr_seen = 0;
    while ((idx < nb || !load_done) && cyc < 400) begin
      in_valid = (idx < nb) && (mem_we || $urandom_range(0, 2) != 0);
      in_data  = (idx < nb) ? b[idx] : c;
      if (mem_we) begin
        wr_seen++;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_write_ready got=%b exp=0", in_ready); end
      end
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1 cycles=%0d", load_done, cyc); end
    total++; if (wr_seen !== 5 || wa.size() !== 5) begin bad++; $display("FAIL b2b_pulses got=%0d/%0d exp=5", wr_seen, wa.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        total++; if (wa[i] !== 20'(i) || wd[i] !== words[i]) begin bad++; $display("FAIL b2b_word%0d got=%h/%h exp=%h/%h", i, wa[i], wd[i], i, words[i]); end
      end
    end
  endtask

  task test_rst_mid;
    pulse_restart();
    words[0] = 16'hC0DE; words[1] = 16'hBEEF; words[2] = 16'h1357;
    send_byte(8'h00); send_byte(8'h03); send_byte(8'hC0); send_byte(8'hDE);
    rst = 1'b0;
    #1;
    total++; if (mem_we !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_we_ready got=%b/%b exp=0/0", mem_we, in_ready); end
    total++; if (mem_wdata !== 16'h0 || mem_addr !== 20'h0) begin bad++; $display("FAIL rstmid_port got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    total++; if (cpu_hold !== 1'b1 || load_done !== 1'b0) begin bad++; $display("FAIL rstmid_status got=%b/%b exp=1/0", cpu_hold, load_done); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_log();
    send_frame(3);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h0B);
`endif
    repeat (2) @(negedge clk);
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL rstmid_done got=%b exp=1", load_done); end
    total++; if (wa.size() !== 3) begin bad++; $display("FAIL rstmid_nwrites got=%0d exp=3", wa.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        total++; if (wa[i] !== 20'(i) || wd[i] !== words[i]) begin bad++; $display("FAIL rstmid_word%0d got=%h/%h exp=%h/%h", i, wa[i], wd[i], i, words[i]); end
      end
    end
  endtask

  task test_addr_wrap;
    pulse_restart();
    clear_log();
    words[0] = 16'hC0DE; words[1] = 16'hBEEF; words[2] = 16'h1357;
    send_frame(3);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h0B);
`endif
    repeat (2) @(negedge clk);
    total++; if (load_done2 !== 1'b1) begin bad++; $display("FAIL wrap_done got=%b exp=1", load_done2); end
    total++; if (wa2.size() !== 3) begin bad++; $display("FAIL wrap_nwrites got=%0d exp=3", wa2.size()); end
    else begin
      total++; if (wa2[0] !== 4'd14) begin bad++; $display("FAIL wrap_a0 got=%0d exp=14", wa2[0]); end
      total++; if (wa2[1] !== 4'd15) begin bad++; $display("FAIL wrap_a1 got=%0d exp=15", wa2[1]); end
      total++; if (wa2[2] !== 4'd0) begin bad++; $display("FAIL wrap_a2 got=%0d exp=0", wa2[2]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_bad_chk();
`endif
    test_empty();
    test_restart();
    test_back_to_back();
    test_rst_mid();
    test_addr_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the fetch stage reads; it is the other end of the instruction-memory interface.
- Receives a framed byte stream over a valid/ready handshake, assembles 16-bit instruction words and writes them to consecutive word addresses.
- Holds the core in reset (cpu_hold) until a complete, checked image has been written.
- Sits between the external boot link and the instruction memory write port.

Parameters:
- ADDR_W, 20, instruction-memory word-address width; addresses wrap modulo 2^ADDR_W.
- START_ADDR, 0, word address of the first written instruction.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- restart  in  1  synchronous, 1-cycle pulse; abort any load and re-arm for a new frame.
- in_valid  in  1  byte available.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts the byte this cycle.
- mem_we  out  1  instruction-memory write strobe, 1 cycle per word.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  16  instruction word.
- cpu_hold  out  1  1 = keep fetch/PC in reset.
- load_done  out  1  image loaded and verified; sticky until rst or restart.
- load_err  out  1  checksum mismatch; sticky until rst or restart.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=LEN_HI, addr=START_ADDR, cnt=0, chk=0.
  - in_ready=0, mem_we=0, mem_addr=START_ADDR, mem_wdata=0.
  - cpu_hold=1, load_done=0, load_err=0.
- Byte transfer: a byte moves only on a rising edge with in_valid&in_ready=1. in_ready is registered and is 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK.
- Frame, all fields high byte first: LEN (16-bit word count N), then N words, then 1 checksum byte.
- chk = XOR of every byte after LEN. Length bytes are not included.
- States:
  - LEN_HI -> LEN_LO on byte: capture len[15:8].
  - LEN_LO on byte: capture len[7:0]. If N==0 -> CHK, else -> DATA_HI.
  - DATA_HI -> DATA_LO on byte: capture word[15:8].
  - DATA_LO -> WRITE on byte: capture word[7:0].
  - WRITE (exactly 1 cycle, in_ready=0): mem_we=1, mem_addr=addr, mem_wdata=word. Next edge: addr+1 (wraps), cnt+1. If cnt+1==N -> CHK, else -> DATA_HI.
  - CHK on byte: if byte==chk -> DONE, else -> ERROR.
  - DONE: load_done=1, cpu_hold=0, in_ready=0. Remains here; further bytes are ignored.
  - ERROR: load_err=1, cpu_hold=1, in_ready=0.
- Latency: mem_we rises in the cycle after the edge that accepts a word's low byte.
- Peak rate: one word per 3 cycles.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- restart (any state): on the next edge, state=LEN_HI, addr=START_ADDR, cnt=0, chk=0, cpu_hold=1, load_done=0, load_err=0.
  - restart takes priority over a byte accepted in the same cycle; that byte is dropped.
  - restart during WRITE suppresses nothing: the mem_we already asserted in that cycle completes.
- Asynchronous reset mid-load: immediate return to the reset values. Memory contents are not cleared.
- N=65535 is legal; cnt is 16 bits. Address wrap past 2^ADDR_W-1 continues at 0 with no error.
- in_valid may drop at any time. The loader waits indefinitely, with no timeout.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined: CHK state, checksum byte and ERROR path exactly as above.
- Undefined:
  - No checksum byte; the last WRITE goes directly to DONE, and N==0 goes from LEN_LO directly to DONE.
  - load_err is tied to 0 and the ERROR state does not exist.

Test Plan:
- Reset release, frame 00 02 | 12 34 | AB CD | chk 0x40 (0x12^0x34^0xAB^0xCD) -> writes (START_ADDR,0x1234), (START_ADDR+1,0xABCD); load_done=1 and cpu_hold=0 one edge after the chk byte.
- Same frame with chk 0x41 -> both words written, load_err=1, cpu_hold stays 1; restart pulse clears load_err; a good frame then loads.
- Frame 00 00 | 00 -> no mem_we, load_done=1. With the macro undefined, frame 00 00 -> load_done=1 right after LEN_LO.
- in_valid toggled randomly and held high during WRITE -> in_ready=0 in every WRITE cycle, no byte lost or duplicated, exactly N mem_we pulses.
- rst driven low mid-data after 1 of 3 words -> outputs return to reset values immediately; a re-sent full frame writes starting again at START_ADDR.
- ADDR_W=4, START_ADDR=14, N=3 -> write addresses 14, 15, 0.
